banked_pixel_mem: RTL and testbench

Parametrised multi-bank pixel/data memory serving the CPU load/store path and the display scan-out path from a single clock. It extends the earlier screen data memory in four ways: N selectable banks of configurable depth and pixel width, true read-modify-write byte stores, range and mode error reporting, and a hardware fill engine that clears a bank to a colour. It sits between the CPU memory stage (load/store unit) and the VGA scan-out logic.

---
 rtl/banked_pixel_mem.sv | 244 ++++++++++++++++++++++++
 tb/tb_banked_pixel_mem.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/banked_pixel_mem.sv
// banked_pixel_mem: multi-bank pixel memory shared by the CPU load/store path
// (port A, with byte read-modify-write and a colour fill engine) and the
// display scan-out path (port B, read-only, one-cycle registered).
module banked_pixel_mem #(
   parameter int BANKS  = 2,
   parameter int DEPTH  = 19200,
   parameter int ADDR_W = 15,
   parameter int PIX_W  = 12
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        bank_sel,
   input  logic [2:0]        mode,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ack,
   output logic              err,
   output logic              busy,
   input  logic              fill_start,
   input  logic [2:0]        fill_bank,
   input  logic [PIX_W-1:0]  fill_color,
   output logic              fill_done,
   input  logic [2:0]        disp_bank,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [PIX_W-1:0]  disp_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RMW, FILL} state_t;

   state_t           state;
   logic [2:0]       op_bank;
   logic [IDX_W-1:0] op_idx;
   logic [2:0]       op_mode;
   logic [7:0]       op_byte;
   logic             op_err;
   logic [2:0]       fill_bank_q;
   logic             fill_ok;
   logic [IDX_W-1:0] fill_cnt;
   logic [2:0]       disp_bank_q;
   logic             disp_ok_q;

   // Request decode; out-of-range indices are clamped so RAM accesses stay in bounds
   logic             req_bank_ok, req_addr_ok, req_mode_ok, req_err, req_is_byte;
   logic [2:0]       req_bank;
   logic [IDX_W-1:0] req_idx;
   logic             disp_ok;
   logic [IDX_W-1:0] disp_idx;
   logic             fill_bank_ok;
   logic             unused_wdata;

   assign req_bank_ok  = 32'(bank_sel) < BANKS;
   assign req_addr_ok  = 32'(addr) < DEPTH;
   assign req_mode_ok  = mode <= 3'd4;
   assign req_err      = !(req_bank_ok && req_addr_ok && req_mode_ok);
   assign req_is_byte  = (mode == 3'd3) || (mode == 3'd4);
   assign req_bank     = req_bank_ok ? bank_sel : 3'd0;
   assign req_idx      = req_addr_ok ? addr[IDX_W-1:0] : '0;
   assign disp_ok      = (32'(disp_bank) < BANKS) && (32'(disp_addr) < DEPTH);
   assign disp_idx     = disp_ok ? disp_addr[IDX_W-1:0] : '0;
   assign fill_bank_ok = 32'(fill_bank) < BANKS;
   assign unused_wdata = ^wdata[31:PIX_W];
   assign busy         = (state != IDLE);

   // Port A signals shared by every bank, plus per-bank read registers
   logic             a_we;
   logic [2:0]       a_bank;
   logic [IDX_W-1:0] a_idx;
   logic [PIX_W-1:0] a_wdata;
   logic [PIX_W-1:0] a_q_all [BANKS];
   logic [PIX_W-1:0] b_q_all [BANKS];
   logic [PIX_W-1:0] a_sel;
   logic [PIX_W-1:0] b_sel;
   logic [15:0]      pix16;
   logic [31:0]      load_val;

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [PIX_W-1:0] ram [DEPTH];
      logic [PIX_W-1:0] a_q;
      logic [PIX_W-1:0] b_q;

      // Port A: write when selected, read every cycle (old data on collision)
      always_ff @(posedge clk) begin
         if (a_we && (a_bank == 3'(b)))
            ram[a_idx] <= a_wdata;
         a_q <= ram[a_idx];
      end

      // Port B: display read every cycle, independent of port A traffic
      always_ff @(posedge clk) begin
         b_q <= ram[disp_idx];
      end

      assign a_q_all[b] = a_q;
      assign b_q_all[b] = b_q;
   end

   // Select the port A read word for the bank held by the in-flight request
   always_comb begin
      a_sel = '0;
      for (int b = 0; b < BANKS; b++)
         if (op_bank == 3'(b))
            a_sel = a_q_all[b];
   end

   // Select the display word for the bank requested in the previous cycle
   always_comb begin
      b_sel = '0;
      for (int b = 0; b < BANKS; b++)
         if (disp_bank_q == 3'(b))
            b_sel = b_q_all[b];
   end

   assign disp_data = disp_ok_q ? b_sel : '0;

   // Load formatting: zero-extend the pixel, then sign/zero-extend per mode
   always_comb begin
      pix16 = 16'(a_sel);
      case (op_mode)
         3'd0:    load_val = 32'(a_sel);
         3'd1:    load_val = {{16{pix16[15]}}, pix16};
         3'd2:    load_val = {16'h0000, pix16};
         3'd3:    load_val = {{24{pix16[7]}}, pix16[7:0]};
         3'd4:    load_val = {24'h000000, pix16[7:0]};
         default: load_val = 32'h0;
      endcase
   end

   // Port A arbitration: direct stores in IDLE, merge write in RMW, colour in FILL
   always_comb begin
      a_we    = 1'b0;
      a_bank  = req_bank;
      a_idx   = req_idx;
      a_wdata = wdata[PIX_W-1:0];
      case (state)
         IDLE: a_we = req && we && !fill_start && !req_is_byte && !req_err;
         LOAD: begin
            a_bank = op_bank;
            a_idx  = op_idx;
         end
         RMW: begin
            a_bank  = op_bank;
            a_idx   = op_idx;
            a_wdata = {a_sel[PIX_W-1:8], op_byte};
            a_we    = !op_err;
         end
         FILL: begin
            a_bank  = fill_bank_q;
            a_idx   = fill_cnt;
            a_wdata = fill_color;
            a_we    = fill_ok;
         end
         default: a_we = 1'b0;
      endcase
      if (!rstn)
         a_we = 1'b0;
   end

   // Display bank/valid tracking so disp_data lines up with the registered read
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         disp_bank_q <= 3'd0;
         disp_ok_q   <= 1'b0;
      end else begin
         disp_bank_q <= disp_bank;
         disp_ok_q   <= disp_ok;
      end
   end

   // Control FSM: accepts requests and fills, emits ack/err/rdata/fill_done pulses
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         ack         <= 1'b0;
         err         <= 1'b0;
         rdata       <= 32'h0;
         fill_done   <= 1'b0;
         fill_cnt    <= '0;
         fill_bank_q <= 3'd0;
         fill_ok     <= 1'b0;
         op_bank     <= 3'd0;
         op_idx      <= '0;
         op_mode     <= 3'd0;
         op_byte     <= 8'h00;
         op_err      <= 1'b0;
      end else begin
         ack       <= 1'b0;
         err       <= 1'b0;
         rdata     <= 32'h0;
         fill_done <= 1'b0;
         case (state)
            IDLE: begin
               if (fill_start) begin
                  state       <= FILL;
                  fill_cnt    <= '0;
                  fill_bank_q <= fill_bank_ok ? fill_bank : 3'd0;
                  fill_ok     <= fill_bank_ok;
               end else if (req) begin
                  op_bank <= req_bank;
                  op_idx  <= req_idx;
                  op_mode <= mode;
                  op_byte <= wdata[7:0];
                  op_err  <= req_err;
                  if (!we) begin
                     state <= LOAD;
                  end else if (req_is_byte) begin
                     state <= RMW;
                  end else begin
                     ack <= 1'b1;
                     err <= req_err;
                  end
               end
            end
            LOAD: begin
               ack   <= 1'b1;
               err   <= op_err;
               rdata <= op_err ? 32'h0 : load_val;
               state <= IDLE;
            end
            RMW: begin
               ack   <= 1'b1;
               err   <= op_err;
               state <= IDLE;
            end
            FILL: begin
               if (fill_cnt == LAST_IDX) begin
                  state     <= IDLE;
                  fill_done <= 1'b1;
                  fill_cnt  <= '0;
               end else begin
                  fill_cnt <= fill_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_banked_pixel_mem.sv
// tb_banked_pixel_mem: randomized and directed checks of banked_pixel_mem
// against an array-based reference model of the pixel banks.
module tb_banked_pixel_mem;

   localparam int BANKS  = 2;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 5;
   localparam int PIX_W  = 12;

   logic              clk;
   logic              rstn;
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [2:0]        bank_sel;
   logic [2:0]        mode;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ack;
   logic              err;
   logic              busy;
   logic              fill_start;
   logic [2:0]        fill_bank;
   logic [PIX_W-1:0]  fill_color;
   logic              fill_done;
   logic [2:0]        disp_bank;
   logic [ADDR_W-1:0] disp_addr;
   logic [PIX_W-1:0]  disp_data;

   int checks = 0;
   int errors = 0;

   logic [PIX_W-1:0] model [BANKS][DEPTH];

   banked_pixel_mem #(
      .BANKS(BANKS), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
   ) dut (
      .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr),
      .bank_sel(bank_sel), .mode(mode), .wdata(wdata), .rdata(rdata),
      .ack(ack), .err(err), .busy(busy), .fill_start(fill_start),
      .fill_bank(fill_bank), .fill_color(fill_color), .fill_done(fill_done),
      .disp_bank(disp_bank), .disp_addr(disp_addr), .disp_data(disp_data)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so a stuck design can never hang the run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] expect_load(input int b, input int a, input int m);
      int p, h, y;
      if (b >= BANKS || a >= DEPTH || m > 4) return 32'h0;
      p = int'(model[b][a]);
      h = p % 65536;
      y = p % 256;
      case (m)
         0: return 32'(p);
         1: return 32'((h >= 32768) ? h - 65536 : h);
         2: return 32'(h);
         3: return 32'((y >= 128) ? y - 256 : y);
         default: return 32'(y);
      endcase
   endfunction

   // One CPU request, called at #1 after a rising edge with the DUT idle
   task automatic apply_stimulus(input bit w, input int b, input int a, input int m,
                                 input logic [31:0] wd);
      int  lat;
      bit  bad;
      int  exp_lat;
      req = 1'b1; we = w; bank_sel = 3'(b); addr = ADDR_W'(a); mode = 3'(m); wdata = wd;
      @(posedge clk); #1;
      req = 1'b0;
      lat = 1;
      while (!ack && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      bad     = (b >= BANKS) || (a >= DEPTH) || (m > 4);
      exp_lat = (!w || m == 3 || m == 4) ? 2 : 1;
      check_output($sformatf("lat w%0d b%0d a%0d m%0d", w, b, a, m), 32'(lat), 32'(exp_lat));
      check_output($sformatf("err w%0d b%0d a%0d m%0d", w, b, a, m), 32'(err), 32'(bad));
      if (!w)
         check_output($sformatf("rdata b%0d a%0d m%0d", b, a, m), rdata, expect_load(b, a, m));
      if (w && !bad) begin
         if (m == 3 || m == 4)
            model[b][a] = {model[b][a][PIX_W-1:8], wd[7:0]};
         else
            model[b][a] = wd[PIX_W-1:0];
      end
   endtask

   // Display read, checked one cycle after the address is presented
   task automatic disp_check(input int b, input int a);
      logic [31:0] exp;
      disp_bank = 3'(b); disp_addr = ADDR_W'(a);
      @(posedge clk); #1;
      exp = (b < BANKS && a < DEPTH) ? 32'(model[b][a]) : 32'h0;
      check_output($sformatf("disp b%0d a%0d", b, a), 32'(disp_data), exp);
   endtask

   // Bank fill, optionally racing a load request on the same edge
   task automatic run_fill(input int fb, input logic [PIX_W-1:0] color, input bit with_req);
      int cycles, acks, dones;
      fill_start = 1'b1; fill_bank = 3'(fb); fill_color = color;
      if (with_req) begin
         req = 1'b1; we = 1'b0; bank_sel = 3'd1; addr = ADDR_W'(3); mode = 3'd0;
      end
      @(posedge clk); #1;
      fill_start = 1'b0; req = 1'b0;
      cycles = 0; acks = 0; dones = 0;
      while (busy && cycles < 100) begin
         cycles++;
         acks  += int'(ack);
         dones += int'(fill_done);
         @(posedge clk); #1;
      end
      check_output($sformatf("fill%0d busy cycles", fb), 32'(cycles), 32'(DEPTH));
      check_output($sformatf("fill%0d ack during fill", fb), 32'(acks), 32'h0);
      check_output($sformatf("fill%0d early done", fb), 32'(dones), 32'h0);
      check_output($sformatf("fill%0d done pulse", fb), 32'(fill_done), 32'h1);
      @(posedge clk); #1;
      check_output($sformatf("fill%0d done width", fb), 32'(fill_done), 32'h0);
      check_output($sformatf("fill%0d no late ack", fb), 32'(ack), 32'h0);
      if (fb < BANKS)
         for (int i = 0; i < DEPTH; i++) model[fb][i] = color;
   endtask

   initial begin
      rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; bank_sel = 3'd0; mode = 3'd0;
      wdata = 32'h0; fill_start = 1'b0; fill_bank = 3'd0; fill_color = '0;
      disp_bank = 3'd0; disp_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset ack", 32'(ack), 32'h0);
      check_output("reset err", 32'(err), 32'h0);
      check_output("reset rdata", rdata, 32'h0);
      check_output("reset fill_done", 32'(fill_done), 32'h0);
      check_output("reset busy", 32'(busy), 32'h0);
      check_output("reset disp_data", 32'(disp_data), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Known contents for bank 1, then the racing fill of bank 0
      run_fill(1, 12'h5A5, 1'b0);
      run_fill(0, 12'h00F, 1'b1);
      for (int i = 0; i < DEPTH; i++) disp_check(0, i);
      apply_stimulus(1'b0, 1, 3, 0, 32'h0);

      // Word store then load, and back-to-back store/load
      apply_stimulus(1'b1, 1, 10, 0, 32'h0000_0ABC);
      apply_stimulus(1'b0, 1, 10, 0, 32'h0);

      // Byte store preserving upper pixel bits, then byte and half loads
      apply_stimulus(1'b1, 0, 5, 0, 32'h0000_0F12);
      apply_stimulus(1'b1, 0, 5, 3, 32'h0000_0034);
      apply_stimulus(1'b0, 0, 5, 3, 32'h0);
      apply_stimulus(1'b0, 0, 5, 1, 32'h0);
      apply_stimulus(1'b0, 0, 5, 0, 32'h0);

      // Sign extension of a byte with its top bit set
      apply_stimulus(1'b1, 0, 6, 0, 32'h0000_00A5);
      apply_stimulus(1'b0, 0, 6, 3, 32'h0);
      apply_stimulus(1'b0, 0, 6, 4, 32'h0);
      apply_stimulus(1'b0, 0, 6, 2, 32'h0);

      // Error cases: bad bank, bad address, bad mode, bad-bank byte store
      apply_stimulus(1'b1, 3, 2, 0, 32'h0000_0123);
      apply_stimulus(1'b0, 1, 2, 0, 32'h0);
      apply_stimulus(1'b0, 0, 16, 0, 32'h0);
      apply_stimulus(1'b1, 0, 2, 6, 32'h0000_0777);
      apply_stimulus(1'b0, 0, 2, 6, 32'h0);
      apply_stimulus(1'b1, 2, 4, 3, 32'h0000_00FF);
      apply_stimulus(1'b0, 0, 2, 0, 32'h0);

      // Fill of a nonexistent bank must not disturb any real bank
      run_fill(5, 12'h777, 1'b0);
      disp_check(0, 2);
      disp_check(1, 10);
      disp_check(2, 0);
      disp_check(0, 20);

      // Randomized traffic, including out-of-range banks, addresses and modes
      for (int n = 0; n < 150; n++) begin
         int rb, ra, rm;
         bit rw;
         rb = int'($urandom_range(0, 2));
         ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
         rm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
         rw = 1'($urandom_range(0, 1));
         apply_stimulus(rw, rb, ra, rm, $urandom);
      end
      for (int n = 0; n < 40; n++)
         disp_check(int'($urandom_range(0, 2)), int'($urandom_range(0, 17)));

      // Reset during a fill at count 7: prefix written, rest preserved
      fill_start = 1'b1; fill_bank = 3'd1; fill_color = 12'h333;
      @(posedge clk); #1;
      fill_start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check_output("midfill reset busy", 32'(busy), 32'h0);
      check_output("midfill reset done", 32'(fill_done), 32'h0);
      @(posedge clk); #1;
      check_output("midfill held done", 32'(fill_done), 32'h0);
      check_output("midfill held ack", 32'(ack), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      check_output("midfill after busy", 32'(busy), 32'h0);
      check_output("midfill after done", 32'(fill_done), 32'h0);
      for (int i = 0; i < 7; i++) model[1][i] = 12'h333;
      for (int i = 0; i < DEPTH; i++) disp_check(1, i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
